bird_mmio: RTL and testbench
============================

Name: bird_mmio

Overview:
Memory-mapped I/O bridge directly downstream of the bird CPU bus (address, data_out, memwt, data_in).
- Decodes each CPU address to either external RAM or one of three I/O registers.
- Returns read data to the CPU combinationally.
- Owns the pushbutton path: synchronizer, debouncer and latched press flag.
- Owns a 4-digit hex 7-segment display register and its scan driver.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced button level changes (minimum 2).
SCAN_BITS, 16, width of the display scan counter; the top 2 bits select the digit.
IO_BASE, 16'hF000, first I/O address; everything below it is RAM.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cpu_address  in  16  CPU bus address
cpu_wdata  in  16  CPU write data (CPU data_out)
cpu_memwt  in  1  CPU write strobe, one cycle per store/push/call
cpu_rdata  out  16  read data to the CPU (CPU data_in); combinational
ram_we  out  1  external RAM write enable
ram_rdata  in  16  external RAM asynchronous read data
pushbutton  in  1  raw, asynchronous, bouncing button
anode  out  4  digit enables, active-low, one-hot-zero
cathode  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
Address map:
- RAM: below IO_BASE.
- IO_BASE+0 BTN_STAT: bit0 = press pending; other bits read 0. A write of any value clears the flag.
- IO_BASE+1 BTN_LVL: bit0 = debounced level; read-only, writes ignored.
- IO_BASE+2 DISP: 16-bit read/write display value.
- IO_BASE+3 to 16'hFFFF: read 16'h0000, writes ignored.

Bus:
- ram_we = cpu_memwt and (cpu_address < IO_BASE).
- cpu_rdata selects ram_rdata or the addressed register, combinationally, in the same cycle the address is presented. The CPU samples it at the next edge.
- Register writes take effect on the clk edge where cpu_memwt=1.

Reset (synchronous, rst=1 at an edge):
- Sync flops, debounced level, pending flag, debounce counter, scan counter and DISP all go to 0.
- anode=4'b1110, cathode=7'b1000000 (digit 0 shows "0").
- ram_we and cpu_rdata are not registered; they follow their inputs during reset.

Button path:
- Two-flop synchronizer: sync1 <= pushbutton; sync2 <= sync1.
- Debounce counter:
  - Resets to 0 whenever sync2 == level.
  - Otherwise increments.
  - If it equals DEBOUNCE_CYCLES-1 on a mismatch, level <= sync2 and the counter returns to 0.
- Net effect: pushbutton high before edge N and held leads to level=1 after edge N+1+DEBOUNCE_CYCLES. Any mismatch run shorter than DEBOUNCE_CYCLES restarts the count, so glitches are ignored.
- Pending flag:
  - Set on the same edge as a 0->1 level transition.
  - Cleared by a write to BTN_STAT.
  - If set and clear occur on the same edge, set wins.
  - A release (1->0) never affects the flag.

Display scan:
- The scan counter increments every cycle and wraps.
- digit = scan[SCAN_BITS-1:SCAN_BITS-2].
- Digit 0 shows DISP[3:0] with anode 1110; digit 3 shows DISP[15:12] with anode 0111.
- anode and cathode are registered: they update one edge after the digit select or DISP changes.
- Hex glyphs are standard for 0-9 and A, b, C, d, E, F.

Reset mid-operation:
- A bouncing or held button during rst has no effect.
- After rst is released, a button that is still held produces a new press after the full debounce time.

Decomposition:
- Package bird_mmio_pkg:
  - address offset constants BTN_STAT_OFS=0, BTN_LVL_OFS=1, DISP_OFS=2;
  - digit-count constant 4;
  - the active-low glyph constant for "0".
- One sub-module, hex7seg: combinational 4-bit to 7-bit active-low decoder, instantiated once on the selected nibble.
- The debouncer stays inline.

Test Plan (DEBOUNCE_CYCLES=4, SCAN_BITS=4):
1. rst for 2 edges, then idle. anode=1110, cathode=1000000, read IO_BASE+2 gives 16'h0000, read IO_BASE+0 gives 16'h0000.
2. pushbutton high from edge 10 and held. BTN_LVL reads 1 and BTN_STAT reads 16'h0001 after edge 15, not before; release leaves BTN_STAT at 1.
3. pushbutton pulses high for 3 cycles, low for 3, high for 2. Level and pending stay 0 throughout.
4. Pending=1, then write 16'h1234 to IO_BASE+0. Reads 0 next cycle. Repeat the write on the exact edge of a new 0->1 level transition: reads 1.
5. Write 16'hA5C3 to IO_BASE+2, then run 64 cycles. Over each 16-cycle scan period, anode/cathode sequence is 1110/"3"=0110000, 1101/"C"=1000110, 1011/"5"=0010010, 0111/"A"=0001000.
6. Write 16'h00FF to address 16'h0100: ram_we=1 in that cycle. Write to IO_BASE+1: ram_we=0 and BTN_LVL unchanged. Read 16'h0100 with ram_rdata=16'hBEEF: cpu_rdata=16'hBEEF. Read 16'hF7FF: cpu_rdata=0.

Source files
------------

// File: rtl/bird_mmio_pkg.sv
// Shared constants for the bird MMIO bridge: register offsets above IO_BASE
// and display geometry.
package bird_mmio_pkg;

  localparam logic [15:0] BTN_STAT_OFS = 16'd0;
  localparam logic [15:0] BTN_LVL_OFS  = 16'd1;
  localparam logic [15:0] DISP_OFS     = 16'd2;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);

  // Active-low {g,f,e,d,c,b,a} pattern for the glyph "0".
  localparam logic [6:0] GLYPH_ZERO = 7'b1000000;

endpackage

// File: rtl/bird_mmio_hex7seg.sv
// Combinational hex nibble to active-low 7-segment decoder, segments {g,f,e,d,c,b,a}.
module hex7seg
  import bird_mmio_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_ZERO;
    unique case (nibble)
      4'h0: seg = GLYPH_ZERO;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = GLYPH_ZERO;
    endcase
  end

endmodule

// File: rtl/bird_mmio.sv
// Memory-mapped I/O bridge for the bird CPU: RAM/IO decode, pushbutton
// synchronizer + debouncer + press flag, and a 4-digit hex display scanner.
module bird_mmio
  import bird_mmio_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          SCAN_BITS       = 16,
  parameter logic [15:0] IO_BASE         = 16'hF000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_memwt,
  output logic [15:0] cpu_rdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  input  logic        pushbutton,
  output logic [3:0]  anode,
  output logic [6:0]  cathode
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                  sync1_q, sync1_d, sync2_q, sync2_d;
  logic                  level_q, level_d, pend_q, pend_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [15:0]           disp_q, disp_d;
  logic [SCAN_BITS-1:0]  scan_q, scan_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            cathode_q, cathode_d;

  logic                  is_io, stat_wr, disp_wr, rise;
  logic [15:0]           io_ofs;
  logic [DIGIT_W-1:0]    digit;
  logic [3:0]            nibble;
  logic [6:0]            seg;

  assign is_io   = (cpu_address >= IO_BASE);
  assign io_ofs  = cpu_address - IO_BASE;
  assign ram_we  = cpu_memwt && !is_io;
  assign stat_wr = cpu_memwt && is_io && (io_ofs == BTN_STAT_OFS);
  assign disp_wr = cpu_memwt && is_io && (io_ofs == DISP_OFS);

  always_comb begin
    cpu_rdata = ram_rdata;
    if (is_io) begin
      if (io_ofs == BTN_STAT_OFS)     cpu_rdata = {15'd0, pend_q};
      else if (io_ofs == BTN_LVL_OFS) cpu_rdata = {15'd0, level_q};
      else if (io_ofs == DISP_OFS)    cpu_rdata = disp_q;
      else                            cpu_rdata = 16'h0000;
    end
  end

  assign digit = scan_q[SCAN_BITS-1 -: DIGIT_W];

  always_comb begin
    nibble = disp_q[3:0];
    case (digit)
      2'd1:    nibble = disp_q[7:4];
      2'd2:    nibble = disp_q[11:8];
      2'd3:    nibble = disp_q[15:12];
      default: nibble = disp_q[3:0];
    endcase
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (seg)
  );

  always_comb begin
    sync1_d = pushbutton;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    rise    = 1'b0;
    // Any return to agreement drops the count, so only an unbroken run flips the level.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise    = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pend_d = pend_q;
    if (stat_wr) pend_d = 1'b0;
    if (rise)    pend_d = 1'b1;
    disp_d    = disp_wr ? cpu_wdata : disp_q;
    scan_d    = scan_q + 1'b1;
    anode_d   = ~(NUM_DIGITS'(1) << digit);
    cathode_d = seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      disp_q    <= '0;
      scan_q    <= '0;
      anode_q   <= 4'b1110;
      cathode_q <= GLYPH_ZERO;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      scan_q    <= scan_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_bird_mmio.sv
// Self-checking bench for bird_mmio: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bird_mmio;

  localparam int          DEB = 4;
  localparam int          SB  = 4;
  localparam logic [15:0] IOB = 16'hF000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_address = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_memwt = 1'b0;
  logic [15:0] cpu_rdata;
  logic        ram_we;
  logic [15:0] ram_rdata = '0;
  logic        pushbutton = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  cathode;

  int checks = 0;
  int errors = 0;

  bird_mmio #(
    .DEBOUNCE_CYCLES (DEB),
    .SCAN_BITS       (SB),
    .IO_BASE         (IOB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_memwt   (cpu_memwt),
    .cpu_rdata   (cpu_rdata),
    .ram_we      (ram_we),
    .ram_rdata   (ram_rdata),
    .pushbutton  (pushbutton),
    .anode       (anode),
    .cathode     (cathode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Behavioural model: state as the spec describes it, advanced once per edge.
  bit          m_valid = 0;
  bit          m_pipe[$];
  int          m_run, m_scan;
  bit          m_lvl, m_pend;
  int          m_disp;
  logic [3:0]  m_anode;
  logic [6:0]  m_cathode;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_pipe.delete();
      m_pipe.push_back(1'b0);
      m_pipe.push_back(1'b0);
      m_run = 0; m_scan = 0; m_lvl = 0; m_pend = 0; m_disp = 0;
      m_anode = 4'b1110; m_cathode = 7'b1000000;
    end else if (m_valid) begin
      int d;
      bit seen, rose;
      d = m_scan / (1 << (SB - 2));
      m_anode = 4'(15 - (1 << d));
      m_cathode = glyph((m_disp >> (4 * d)) % 16);
      m_scan = (m_scan + 1) % (1 << SB);
      seen = m_pipe.pop_front();
      m_pipe.push_back(pushbutton);
      rose = 0;
      if (seen == m_lvl) m_run = 0;
      else begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl = seen;
          m_run = 0;
          rose = seen;
        end
      end
      if (cpu_memwt && cpu_address == IOB) m_pend = 0;
      if (rose) m_pend = 1;
      if (cpu_memwt && cpu_address == IOB + 16'd2) m_disp = int'(cpu_wdata);
    end
  end

  function automatic logic [15:0] exp_rdata();
    if (cpu_address < IOB) return ram_rdata;
    if (cpu_address == IOB)         return {15'd0, m_pend};
    if (cpu_address == IOB + 16'd1) return {15'd0, m_lvl};
    if (cpu_address == IOB + 16'd2) return 16'(m_disp);
    return 16'h0000;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("anode", anode, m_anode);
      chk("cathode", cathode, m_cathode);
      chk("ram_we", ram_we, cpu_memwt && (cpu_address < IOB));
      chk("cpu_rdata", cpu_rdata, exp_rdata());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string name);
    cpu_memwt = 1'b0;
    cpu_address = addr;
    #1;
    chk(name, cpu_rdata, exp);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    cpu_address = addr;
    cpu_wdata = data;
    cpu_memwt = 1'b1;
    cyc();
    cpu_memwt = 1'b0;
  endtask

  initial begin
    int cnt [4];
    int pb_left, rst_left, r;

    // Reset and idle state
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_anode", anode, 4'b1110);
    chk("rst_cathode", cathode, 7'b1000000);
    rd(IOB + 16'd2, 16'h0000, "rst_disp");
    rd(IOB, 16'h0000, "rst_stat");
    repeat (3) cyc();

    // Held press: level rises on the fifth edge after the first sampling edge
    pushbutton = 1'b1;
    repeat (5) cyc();
    rd(IOB + 16'd1, 16'h0000, "lvl_early");
    rd(IOB, 16'h0000, "stat_early");
    cyc();
    rd(IOB + 16'd1, 16'h0001, "lvl_on_time");
    rd(IOB, 16'h0001, "stat_on_time");
    pushbutton = 1'b0;
    repeat (12) cyc();
    rd(IOB, 16'h0001, "stat_after_release");
    rd(IOB + 16'd1, 16'h0000, "lvl_after_release");
    wr(IOB, 16'h1234);
    rd(IOB, 16'h0000, "stat_cleared");

    // Glitches shorter than the debounce window
    pushbutton = 1'b1; repeat (3) cyc();
    pushbutton = 1'b0; repeat (3) cyc();
    pushbutton = 1'b1; repeat (2) cyc();
    pushbutton = 1'b0; repeat (10) cyc();
    rd(IOB + 16'd1, 16'h0000, "glitch_lvl");
    rd(IOB, 16'h0000, "glitch_stat");

    // Clear on the same edge as a new rise: set wins
    pushbutton = 1'b1;
    repeat (5) cyc();
    cpu_address = IOB; cpu_wdata = 16'h1234; cpu_memwt = 1'b1;
    cyc();
    cpu_memwt = 1'b0;
    rd(IOB, 16'h0001, "set_wins");
    pushbutton = 1'b0;
    repeat (10) cyc();
    wr(IOB, 16'h0000);

    // Reset during a held press: full debounce after release
    pushbutton = 1'b1;
    repeat (3) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (5) cyc();
    rd(IOB + 16'd1, 16'h0000, "post_rst_early");
    cyc();
    rd(IOB + 16'd1, 16'h0001, "post_rst_lvl");
    rd(IOB, 16'h0001, "post_rst_stat");
    pushbutton = 1'b0;
    repeat (10) cyc();
    wr(IOB, 16'h0000);

    // Display scan of A5C3
    wr(IOB + 16'd2, 16'hA5C3);
    repeat (2) cyc();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int i = 0; i < 16; i++) begin
      case (anode)
        4'b1110: begin cnt[0]++; chk("scan_d0", cathode, 7'b0110000); end
        4'b1101: begin cnt[1]++; chk("scan_d1", cathode, 7'b1000110); end
        4'b1011: begin cnt[2]++; chk("scan_d2", cathode, 7'b0010010); end
        4'b0111: begin cnt[3]++; chk("scan_d3", cathode, 7'b0001000); end
        default: chk("scan_anode_onehot", anode, 4'b1110);
      endcase
      cyc();
    end
    for (int i = 0; i < 4; i++) chk("scan_dwell", cnt[i], 4);
    repeat (48) cyc();

    // Bus decode
    cpu_address = 16'h0100; cpu_wdata = 16'h00FF; cpu_memwt = 1'b1;
    #1 chk("ram_we_ram", ram_we, 1'b1);
    cyc();
    cpu_address = IOB + 16'd1; cpu_wdata = 16'hFFFF; cpu_memwt = 1'b1;
    #1 chk("ram_we_io", ram_we, 1'b0);
    cyc();
    cpu_memwt = 1'b0;
    rd(IOB + 16'd1, 16'h0000, "lvl_readonly");
    cyc();
    ram_rdata = 16'hBEEF;
    rd(16'h0100, 16'hBEEF, "ram_read");
    rd(16'hF7FF, 16'h0000, "unmapped_read");
    cyc();

    // Randomized traffic against the model
    pb_left = 0;
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (pb_left == 0) begin
        pushbutton = ~pushbutton;
        pb_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
      end
      pb_left--;
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      rst = (rst_left > 0);
      r = $urandom_range(0, 9);
      if (r < 4)      cpu_address = 16'($urandom_range(0, 32'hEFFF));
      else if (r < 8) cpu_address = IOB + 16'(r - 4);
      else if (r == 8) cpu_address = 16'($urandom_range(32'hF004, 32'hFFFF));
      else            cpu_address = 16'hFFFF;
      cpu_memwt = ($urandom_range(0, 3) == 0);
      cpu_wdata = 16'($urandom);
      ram_rdata = 16'($urandom);
      cyc();
    end
    rst = 1'b0;
    cpu_memwt = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
